// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the decode-to-execute pipeline register:
//   - default datapath / field widths for the RV32 core
//   - writeback-select and load-size encodings
//   - id_ex_payload_t, the packed layout of every payload field, MSB first
//     in the same order the stage packs its payload vector
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int DEF_XLEN    = 32;
    localparam int DEF_RA_W    = 5;
    localparam int DEF_ALUOP_W = 4;
    localparam int DEF_WBSEL_W = 3;

    typedef enum logic [DEF_WBSEL_W-1:0] {
        WB_ALU    = 3'd0,
        WB_LOAD   = 3'd1,
        WB_IMM    = 3'd2,
        WB_IADDER = 3'd3,
        WB_CSR    = 3'd4,
        WB_PC4    = 3'd5
    } wb_sel_e;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } load_size_e;

    typedef struct packed {
        logic [DEF_RA_W-1:0]    rd_addr;
        logic [DEF_XLEN-1:0]    rs1;
        logic [DEF_XLEN-1:0]    rs2;
        logic [DEF_XLEN-1:0]    pc;
        logic [DEF_XLEN-1:0]    pc_plus_4;
        logic [DEF_XLEN-1:0]    iadder;
        logic [DEF_ALUOP_W-1:0] aluopcode;
        logic [1:0]             load_size;
        logic                   load_unsigned;
        logic                   alu_src;
        logic [DEF_WBSEL_W-1:0] wb_mux_sel;
        logic                   immd;
        logic                   rf_wr_en;
    } id_ex_payload_t;

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg_if
// Decode-side and execute-side bus of the ID/EX stage.
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; the producer holds valid and payload stable until then, and
// ready may not be used by the producer to decide whether to raise valid.
//   slave  : the pipeline register (consumes in_*, produces *_reg_out)
//   master : the environment (decode drives in_*, execute drives out_ready)
// ---------------------------------------------------------------------------
interface id_ex_pipe_reg_if
    import pipe_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RA_W    = DEF_RA_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int WBSEL_W = DEF_WBSEL_W
);
    logic               in_valid;
    logic               in_ready;
    logic               out_valid;
    logic               out_ready;

    logic [RA_W-1:0]    rd_addr_in;
    logic [XLEN-1:0]    rs1_in;
    logic [XLEN-1:0]    rs2_in;
    logic [XLEN-1:0]    pc_in;
    logic [XLEN-1:0]    pc_plus_4_in;
    logic [XLEN-1:0]    iadder_in;
    logic               branchtaken_in;
    logic [ALUOP_W-1:0] aluopcode_in;
    logic [1:0]         load_size_in;
    logic               load_unsigned_in;
    logic               alu_src_in;
    logic               immd_in;
    logic               rf_wr_en_in;
    logic [WBSEL_W-1:0] wb_mux_sel_in;

    logic [RA_W-1:0]    rd_addr_reg_out;
    logic [XLEN-1:0]    rs1_reg_out;
    logic [XLEN-1:0]    rs2_reg_out;
    logic [XLEN-1:0]    pc_reg_out;
    logic [XLEN-1:0]    pc_plus_4_reg_out;
    logic [XLEN-1:0]    iadder_reg_out;
    logic [ALUOP_W-1:0] aluopcode_reg_out;
    logic [1:0]         load_size_reg_out;
    logic               load_unsigned_reg_out;
    logic               alu_src_reg_out;
    logic [WBSEL_W-1:0] wb_mux_sel_reg_out;
    logic               immd_reg_out;
    logic               rf_wr_en_reg_out;

    modport slave (
        input  in_valid, out_ready,
        input  rd_addr_in, rs1_in, rs2_in, pc_in, pc_plus_4_in, iadder_in,
               branchtaken_in, aluopcode_in, load_size_in, load_unsigned_in,
               alu_src_in, immd_in, rf_wr_en_in, wb_mux_sel_in,
        output in_ready, out_valid,
        output rd_addr_reg_out, rs1_reg_out, rs2_reg_out, pc_reg_out,
               pc_plus_4_reg_out, iadder_reg_out, aluopcode_reg_out,
               load_size_reg_out, load_unsigned_reg_out, alu_src_reg_out,
               wb_mux_sel_reg_out, immd_reg_out, rf_wr_en_reg_out
    );

    modport master (
        output in_valid, out_ready,
        output rd_addr_in, rs1_in, rs2_in, pc_in, pc_plus_4_in, iadder_in,
               branchtaken_in, aluopcode_in, load_size_in, load_unsigned_in,
               alu_src_in, immd_in, rf_wr_en_in, wb_mux_sel_in,
        input  in_ready, out_valid,
        input  rd_addr_reg_out, rs1_reg_out, rs2_reg_out, pc_reg_out,
               pc_plus_4_reg_out, iadder_reg_out, aluopcode_reg_out,
               load_size_reg_out, load_unsigned_reg_out, alu_src_reg_out,
               wb_mux_sel_reg_out, immd_reg_out, rf_wr_en_reg_out
    );

endinterface

// File: rtl/pipe_slice.sv
// ---------------------------------------------------------------------------
// pipe_slice
// Generic valid/ready register slice over a W-bit payload vector.
//   clk_in, rst_in (async, active-high), flush_in (drops held + incoming)
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side, fully registered
// SKID=1: main + skid entry, in_ready comes straight from a flop.
// SKID=0: single entry, in_ready is combinational from out_ready.
// out_data holds its last value while out_valid is low.
// ---------------------------------------------------------------------------
module pipe_slice #(
    parameter int W    = 8,
    parameter bit SKID = 1'b1
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         flush_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic main_load;
    logic accept;

    assign main_load = ~out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    generate
        if (SKID) begin : g_skid
            logic         skid_valid;
            logic         ready_q;
            logic [W-1:0] skid_data;

            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    out_valid  <= 1'b0;
                    out_data   <= '0;
                    skid_valid <= 1'b0;
                    skid_data  <= '0;
                    ready_q    <= 1'b0;
                end else if (flush_in) begin
                    out_valid  <= 1'b0;
                    skid_valid <= 1'b0;
                    ready_q    <= 1'b1;
                end else if (main_load) begin
                    if (skid_valid) begin
                        // Drain the skid first so ordering is preserved.
                        out_valid  <= 1'b1;
                        out_data   <= skid_data;
                        skid_valid <= accept;
                        ready_q    <= ~accept;
                        if (accept) begin
                            skid_data <= in_data;
                        end
                    end else begin
                        out_valid <= accept;
                        ready_q   <= 1'b1;
                        if (accept) begin
                            out_data <= in_data;
                        end
                    end
                end else if (accept) begin
                    // Main is stalled: park the new word in the skid.
                    skid_valid <= 1'b1;
                    skid_data  <= in_data;
                    ready_q    <= 1'b0;
                end else begin
                    ready_q <= ~skid_valid;
                end
            end

            assign in_ready = ready_q;
        end else begin : g_noskid
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    out_valid <= 1'b0;
                    out_data  <= '0;
                end else if (flush_in) begin
                    out_valid <= 1'b0;
                end else if (main_load) begin
                    out_valid <= accept;
                    if (accept) begin
                        out_data <= in_data;
                    end
                end
            end

            assign in_ready = ~rst_in & main_load;
        end
    endgenerate

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_reg
// Decode-to-execute pipeline register of the RV32 core.
//   clk_in   : clock, rising edge
//   rst_in   : asynchronous active-high reset, clears outputs and skid
//   flush_in : kills held and incoming instructions on the next edge
//   bus      : id_ex_pipe_reg_if.slave, in_valid/in_ready handshake and the
//              *_in payload from decode; out_valid/out_ready and the
//              *_reg_out payload towards execute
// Branch/jump targets have iadder bit 0 cleared at capture, so the cleared
// value is what travels through the skid entry as well.
// rf_wr_en_reg_out is forced low during bubbles so a stale write enable can
// never reach the register file; other fields just hold.
// ---------------------------------------------------------------------------
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int XLEN    = DEF_XLEN,
    parameter int RA_W    = DEF_RA_W,
    parameter int ALUOP_W = DEF_ALUOP_W,
    parameter int WBSEL_W = DEF_WBSEL_W,
    parameter bit SKID    = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush_in,
    id_ex_pipe_reg_if.slave  bus
);

    localparam int PW = RA_W + 5 * XLEN + ALUOP_W + 2 + 1 + 1 + WBSEL_W + 1 + 1;

    logic [XLEN-1:0] iadder_cap;
    logic [PW-1:0]   d_in;
    logic [PW-1:0]   d_out;
    logic            rf_wr_en_held;

    assign iadder_cap = bus.branchtaken_in ? {bus.iadder_in[XLEN-1:1], 1'b0}
                                           : bus.iadder_in;

    assign d_in = {bus.rd_addr_in, bus.rs1_in, bus.rs2_in, bus.pc_in,
                   bus.pc_plus_4_in, iadder_cap, bus.aluopcode_in,
                   bus.load_size_in, bus.load_unsigned_in, bus.alu_src_in,
                   bus.wb_mux_sel_in, bus.immd_in, bus.rf_wr_en_in};

    pipe_slice #(
        .W    (PW),
        .SKID (SKID)
    ) u_slice (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .flush_in  (flush_in),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (d_in),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (d_out)
    );

    assign {bus.rd_addr_reg_out, bus.rs1_reg_out, bus.rs2_reg_out,
            bus.pc_reg_out, bus.pc_plus_4_reg_out, bus.iadder_reg_out,
            bus.aluopcode_reg_out, bus.load_size_reg_out,
            bus.load_unsigned_reg_out, bus.alu_src_reg_out,
            bus.wb_mux_sel_reg_out, bus.immd_reg_out, rf_wr_en_held} = d_out;

    assign bus.rf_wr_en_reg_out = rf_wr_en_held & bus.out_valid;

endmodule

// File: doc/id_ex_pipe_reg.md
Name: id_ex_pipe_reg

Overview:
- Parametrised decode-to-execute pipeline register for the RV32 core; successor to the fixed stage register.
- Adds a valid/ready handshake, stall, flush/bubble insertion and an optional skid entry that keeps the ready path registered.
- Sits between decode/register-file read and the ALU/branch/load-store execute stage.
- Branch/jump target LSB clearing is kept: bit 0 of iadder is forced to 0 when branch is taken.

Parameters:
- XLEN, 32, datapath width of rs1/rs2/pc/pc_plus_4/iadder.
- RA_W, 5, register address width.
- ALUOP_W, 4, ALU opcode width.
- WBSEL_W, 3, writeback mux select width.
- SKID, 1, 1 = two-entry (main + skid) with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- flush_in  input  1  kill all held and incoming instructions this cycle.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  stage can accept this cycle.
- out_valid  output  1  execute-side payload valid.
- out_ready  input  1  execute consumes payload this cycle.
- rd_addr_in  input  RA_W  destination register.
- rs1_in, rs2_in  input  XLEN  operand values.
- pc_in, pc_plus_4_in  input  XLEN  instruction PC and PC+4.
- iadder_in  input  XLEN  immediate-adder result.
- branchtaken_in  input  1  clear iadder bit 0 on capture.
- aluopcode_in  input  ALUOP_W  ALU opcode.
- load_size_in  input  2  load size.
- load_unsigned_in, alu_src_in, immd_in, rf_wr_en_in  input  1  control bits.
- wb_mux_sel_in  input  WBSEL_W  writeback select.
- Registered payload outputs, same widths as the inputs: rd_addr_reg_out, rs1_reg_out, rs2_reg_out, pc_reg_out, pc_plus_4_reg_out, iadder_reg_out, aluopcode_reg_out, load_size_reg_out, load_unsigned_reg_out, alu_src_reg_out, wb_mux_sel_reg_out, immd_reg_out, rf_wr_en_reg_out.

Behaviour:
- Clock, reset and handshake:
  - One clock, clk_in. Reset rst_in is asynchronous, active-high.
  - Reset clears all payload outputs, out_valid and the skid valid to 0.
  - While in reset, in_ready = 0. in_ready goes to 1 on the first edge after reset deasserts (SKID=1), or immediately (SKID=0).
  - Accept = in_valid & in_ready. Consume = out_valid & out_ready.
  - Latency is 1 cycle: data accepted at edge N appears on the outputs after edge N when the main entry is free.
- Main entry:
  - Loads when ~out_valid | out_ready.
  - Source is the skid entry if the skid is valid, otherwise the input (only on accept).
  - Otherwise the main entry holds and all outputs are stable.
- Capture rules:
  - iadder_reg_out = branchtaken_in ? {iadder_in[XLEN-1:1],1'b0} : iadder_in.
  - The LSB clear is applied at input capture and travels through the skid unchanged.
- SKID=1:
  - in_ready is a register = ~skid_valid.
  - An accept while the main entry holds (out_valid & ~out_ready) writes the skid entry.
  - When the main entry loads from the skid, the skid empties and in_ready returns to 1 next cycle.
  - Simultaneous skid drain and new accept: the skid goes to main and the new input goes to the skid.
  - Order is preserved.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational). There is no skid storage.
- Bubbles:
  - rf_wr_en_reg_out is qualified: it reads 0 whenever out_valid = 0.
  - Other payload bits hold their last value during bubbles (don't-care to consumers).
- flush_in:
  - On the next edge, out_valid = 0, skid valid = 0 and rf_wr_en_reg_out = 0.
  - Any accept in the flush cycle is discarded.
  - Flush has priority over load/hold.
  - in_ready is 1 in the cycle after the flush.
- Mid-operation reset clears everything immediately, including in-flight skid content. No stale output appears after release.
- Simultaneous consume and accept with the main entry valid and skid empty: main takes the new input, full throughput, no bubble.

Decomposition:
- Package pipe_pkg holds:
  - XLEN/RA_W/ALUOP_W/WBSEL_W defaults.
  - wb_mux_sel and load_size encodings.
  - A packed id_ex_payload_t struct grouping every payload field.
- One sub-module, pipe_slice:
  - Generic valid/ready register slice over a packed payload vector.
  - Parameter W and SKID, with flush.
  - id_ex_pipe_reg packs the inputs, applies the iadder LSB rule and instantiates it.

Test Plan:
- Reset asserted mid-stream with the skid full -> all outputs 0, out_valid = 0, in_ready = 0 asynchronously. in_ready = 1 one edge after release.
- Stream of 8 instructions with out_ready = 1, pc 0x100..0x11C -> out_valid each cycle, pc_reg_out follows with 1-cycle latency, no bubbles.
- Stall: out_ready = 0 for 3 cycles while pc 0x200/0x204 offered -> 0x200 held in main, 0x204 in skid, in_ready = 0. Release -> 0x200, 0x204 in order.
- branchtaken_in = 1, iadder_in = 0x0000_1235 -> iadder_reg_out = 0x0000_1234. With branchtaken_in = 0, 0x1235 passes unchanged.
- flush_in while main and skid are valid and in_valid = 1 with rf_wr_en_in = 1 -> next cycle out_valid = 0, rf_wr_en_reg_out = 0, no flushed pc ever appears.
- SKID=0 build: out_ready = 0 with out_valid = 1 -> in_ready = 0 in the same cycle. Repeat the stream test with no ordering loss.
